uart_tx_packet_framer: RTL
==========================

Name: uart_tx_packet_framer

Overview:
- Sits between bram_data_to_serial and uart_tx6 on the transmit path, running on the 96 MHz system clock.
- Wraps each BRAM readout in a frame: SOF byte, length byte, payload bytes, checksum byte.
- Upstream sees it as a UART TX buffer (data/write/full); downstream it drives the uart_tx6 buffer_write interface.
- The MCU starts a frame with a length and gets a done pulse when the checksum byte has been queued.

Parameters:
SOF_BYTE  8'hA5  start-of-frame marker, first byte of every frame
LEN_WIDTH  8  width of payload length field; max payload 2**LEN_WIDTH-1 bytes

Ports:
clk  input  1  system clock (96 MHz domain)
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a frame, sampled only in IDLE
payload_len  input  LEN_WIDTH  payload byte count, captured on accepted start
in_data  input  8  payload byte from upstream
in_write  input  1  upstream byte strobe; accepted only when in_full=0
in_full  output  1  backpressure to upstream
out_data  output  8  byte to uart_tx6 data_in
out_write  output  1  one-cycle strobe to uart_tx6 buffer_write
out_full  input  1  uart_tx6 buffer_full
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after checksum byte is written

Behaviour:
- Reset values: in_full=1, out_data=0, out_write=0, busy=0, done=0, state=IDLE, hold_valid=0, checksum=0, remaining=0.
- All outputs are registered.
- Reset mid-frame aborts immediately. No partial trailer is emitted; bytes already queued in uart_tx6 are not retracted.
- States: IDLE, SOF, LEN, PAYLOAD, CHK, GAP, DONE.
- IDLE: on start=1, latch payload_len into remaining, clear checksum, set busy=1, go to SOF. start while busy is ignored.
- Emit rule, shared by SOF/LEN/PAYLOAD/CHK:
  - A byte is written (out_write=1 for exactly one cycle, out_data valid the same cycle) only in a cycle following one where out_full was sampled 0.
  - After every write the FSM passes through GAP for one cycle before evaluating out_full again. This guarantees at most one write per 2 cycles, so uart_tx6 full has time to update.
  - While out_full=1 the FSM holds state and the pending byte; nothing is dropped.
- SOF: emit SOF_BYTE, then go to LEN.
- LEN: emit the latched length. checksum <= length. Go to PAYLOAD if length!=0, else CHK.
- PAYLOAD:
  - One-byte holding register; in_full = ~(state==PAYLOAD) | hold_valid.
  - in_write while in_full=0 loads hold, sets hold_valid, checksum += in_data (mod 256), remaining -= 1.
  - Hold is emitted per the emit rule and hold_valid is cleared on write.
  - When remaining reaches 0 and the hold is emitted, go to CHK.
  - Byte order preserved exactly.
- CHK: emit (~checksum + 1) mod 256, so that LEN + payload + CHK ≡ 0 mod 256. Then go to DONE.
- DONE: pulse done=1 for one cycle, busy=0, in_full=1, return to IDLE. A start arriving in the DONE cycle is ignored.
- in_write while in_full=1, including outside PAYLOAD: byte ignored, no state change.
- Simultaneous in_write and out_full=1 with hold empty: byte accepted into hold; emission waits.
- Length 0 frame: SOF_BYTE, 0x00, 0x00; upstream never sees in_full=0.
- Length 2**LEN_WIDTH-1 is legal. There is no wrap of remaining.
- Latency with out_full=0 throughout: first out_write 2 cycles after start; minimum frame time 2*(len+3)+2 cycles.

Test Plan:
- Reset, then start, payload_len=4, bytes 01 02 03 04, out_full=0 → out_data sequence A5 04 01 02 03 04 F2, exactly 7 out_write pulses spaced ≥2 cycles apart, done one cycle after last write, busy low after.
- start, payload_len=0 → A5 00 00, in_full stays 1, done pulses.
- payload_len=3 (FF FF FF) with out_full forced 1 for 20 cycles mid-payload → no writes during stall, in_full=1 once hold is full, resumes with A5 03 FF FF FF 00 in order, no loss or duplication.
- in_write pulses while IDLE and during SOF/LEN, then a start pulse while busy → bytes ignored, second start ignored, frame output unchanged.
- rst asserted after SOF and LEN were written, payload pending → next cycle all outputs at reset values; new start with len=1, byte 7F → A5 01 7F 80.
- Random lengths 1..255 with random out_full stalls → scoreboard frame bytes and verify (LEN + payload + CHK) mod 256 == 0.

Source files
------------

// File: rtl/uart_tx_packet_framer.sv
// uart_tx_packet_framer: wraps an upstream byte stream as SOF, length, payload, checksum for uart_tx6
module uart_tx_packet_framer #(
  parameter logic [7:0] SOF_BYTE  = 8'hA5,
  parameter int         LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] payload_len,
  input  logic [7:0]           in_data,
  input  logic                 in_write,
  output logic                 in_full,
  output logic [7:0]           out_data,
  output logic                 out_write,
  input  logic                 out_full,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [2:0] {IDLE, SOF, LEN, PAYLOAD, CHK, GAP, DONE} state_t;
  state_t               state, state_n, ret, ret_n;
  logic [7:0]           hold, hold_n, checksum, checksum_n, data_n;
  logic                 hold_valid, hold_valid_n, wr_n, acc;
  logic [LEN_WIDTH-1:0] remaining, remaining_n;
  // state, holding register and registered outputs; outputs derive from next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ret        <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      checksum   <= '0;
      remaining  <= '0;
      out_data   <= '0;
      out_write  <= 1'b0;
      in_full    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      ret        <= ret_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      checksum   <= checksum_n;
      remaining  <= remaining_n;
      out_data   <= data_n;
      out_write  <= wr_n;
      in_full    <= (state_n != PAYLOAD) | hold_valid_n;
      busy       <= (state_n != IDLE) && (state_n != DONE);
      done       <= state_n == DONE;
    end
  end
  // next-state: every emitted byte is followed by one GAP cycle so uart_tx6 full can settle
  always_comb begin
    state_n      = state;
    ret_n        = ret;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    checksum_n   = checksum;
    remaining_n  = remaining;
    wr_n         = 1'b0;
    data_n       = out_data;
    acc          = in_write & ~in_full;
    case (state)
      IDLE: if (start) begin
        state_n     = SOF;
        remaining_n = payload_len;
        checksum_n  = '0;
      end
      SOF: if (!out_full) begin
        wr_n    = 1'b1;
        data_n  = SOF_BYTE;
        state_n = GAP;
        ret_n   = LEN;
      end
      LEN: if (!out_full) begin
        wr_n       = 1'b1;
        data_n     = 8'(remaining);
        checksum_n = 8'(remaining);
        state_n    = GAP;
        ret_n      = remaining == '0 ? CHK : PAYLOAD;
      end
      PAYLOAD: begin
        if (acc) begin
          checksum_n  = checksum + in_data;
          remaining_n = remaining - LEN_WIDTH'(1);
        end
        if ((hold_valid | acc) & ~out_full) begin
          wr_n         = 1'b1;
          data_n       = hold_valid ? hold : in_data;
          hold_valid_n = 1'b0;
          state_n      = GAP;
          ret_n        = remaining_n == '0 ? CHK : PAYLOAD;
        end else if (acc) begin
          hold_n       = in_data;
          hold_valid_n = 1'b1;
        end
      end
      CHK: if (!out_full) begin
        wr_n    = 1'b1;
        data_n  = ~checksum + 8'd1;
        state_n = GAP;
        ret_n   = DONE;
      end
      GAP:     state_n = ret;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
